// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial sequencer for a 1-bit ALU slice.
// Presents latched operands LSB-first, one bit per clock, ripples the slice
// carry back into the next bit and assembles the slice z outputs into a
// WIDTH-bit result plus a final carry. The operation code is passed through
// untouched; the slice alone defines the function.
module serial_alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       s_op_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout_out,
   output logic             alu_a,
   output logic             alu_b,
   output logic             alu_cin,
   output logic [1:0]       alu_s_op,
   input  logic             alu_z,
   input  logic             alu_cout
);

   // One extra bit so the counter can represent WIDTH itself without wrapping.
   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [1:0]       op_q;
   logic             carry_q;
   logic [CW-1:0]    cnt;
   logic             last_bit;

   assign last_bit = (cnt == CW'(WIDTH - 1));

   // Sequencer state, operand shifters, carry feedback and result assembly.
   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values of the others (the shifters and result rely on it).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         op_q     <= '0;
         carry_q  <= 1'b0;
         cnt      <= '0;
         result   <= '0;
         cout_out <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_sh     <= a_in;
                  b_sh     <= b_in;
                  op_q     <= s_op_in;
                  carry_q  <= cin_in;
                  cnt      <= '0;
                  result   <= '0;
                  cout_out <= 1'b0;
                  state    <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               result  <= {alu_z, result[WIDTH-1:1]};
               carry_q <= alu_cout;
               a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
               cnt     <= cnt + CW'(1);
               if (last_bit) begin
                  cout_out <= alu_cout;
                  state    <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

   // Slice-side outputs come straight from registers, forced to 0 outside RUN.
   assign alu_a    = busy & a_sh[0];
   assign alu_b    = busy & b_sh[0];
   assign alu_cin  = busy & carry_q;
   assign alu_s_op = busy ? op_q : 2'b00;

endmodule
